fetch_sequencer: RTL and testbench

- Instruction-fetch sequencer that sits between the program counter and the decode stage.
- Reads the current PC, fetches the instruction word from instruction memory, and fetches a second operand word for OD (two-word) instructions.
- Presents the instruction to decode through a valid/ready handshake.
- Drives the PC's increment controls: ipc for a one-word instruction, dipc for a two-word instruction.
- Aborts and refetches on a PC load (branch).

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: PC controls, instruction-memory read port and decode handshake.
interface fetch_sequencer_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic [AW-1:0] pc;
    logic          lpc;
    logic          bb;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ir;
    logic [DW-1:0] opnd;
    logic          is_od;
    logic          ipc;
    logic          dipc;

    modport master (
        input  pc, lpc, bb, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, ir, opnd, is_od, ipc, dipc
    );

    modport slave (
        output pc, lpc, bb, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, ir, opnd, is_od, ipc, dipc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: fetches one- or two-word instructions, hands them to decode,
// pulses the PC increment controls on issue and drains/refetches on a PC load.
module fetch_sequencer #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned OD_BIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        OPND  = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] drain_addr;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] opnd_q;
    logic          is_od_q;

    logic          mem_req_c;
    logic [AW-1:0] mem_addr_c;
    logic          out_valid_c;
    logic          ipc_c;
    logic          dipc_c;
    logic          ld_ir;
    logic          ld_opnd;
    logic          clr_opnd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, memory request and issue strobes; lpc overrides every other decision
    always_comb begin
        state_nxt   = state;
        mem_req_c   = 1'b0;
        mem_addr_c  = '0;
        out_valid_c = 1'b0;
        ipc_c       = 1'b0;
        dipc_c      = 1'b0;
        ld_ir       = 1'b0;
        ld_opnd     = 1'b0;
        clr_opnd    = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                mem_req_c  = 1'b1;
                mem_addr_c = bus.pc;
                if (bus.lpc) begin
                    state_nxt = bus.mem_ack ? FETCH : DRAIN;
                end else if (bus.mem_ack) begin
                    ld_ir     = 1'b1;
                    clr_opnd  = ~bus.mem_rdata[OD_BIT];
                    state_nxt = bus.mem_rdata[OD_BIT] ? OPND : ISSUE;
                end
            end
            OPND: begin
                mem_req_c  = 1'b1;
                mem_addr_c = bus.pc + AW'(1);
                if (bus.lpc) begin
                    state_nxt = bus.mem_ack ? FETCH : DRAIN;
                end else if (bus.mem_ack) begin
                    ld_opnd   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.lpc) begin
                    state_nxt = FETCH;
                end else begin
                    out_valid_c = 1'b1;
                    if (bus.out_ready && !bus.bb) begin
                        ipc_c     = ~is_od_q;
                        dipc_c    = is_od_q;
                        state_nxt = FETCH;
                    end
                end
            end
            DRAIN: begin
                // The abandoned read must still complete at its original address
                mem_req_c  = 1'b1;
                mem_addr_c = drain_addr;
                if (bus.mem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction/operand holding registers plus the address kept for a drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            opnd_q     <= '0;
            is_od_q    <= 1'b0;
            drain_addr <= '0;
        end else begin
            if (state != DRAIN) begin
                drain_addr <= mem_addr_c;
            end
            if (ld_ir) begin
                ir_q    <= bus.mem_rdata;
                is_od_q <= bus.mem_rdata[OD_BIT];
            end
            if (clr_opnd) begin
                opnd_q <= '0;
            end else if (ld_opnd) begin
                opnd_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.ir        = ir_q;
    assign bus.opnd      = opnd_q;
    assign bus.is_od     = is_od_q;
    assign bus.ipc       = ipc_c;
    assign bus.dipc      = dipc_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_fetch_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    fetch_sequencer #(.AW(AW), .DW(DW), .OD_BIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rdy;
        logic          bb;
        logic          lpc;
        logic [15:0]   lpc_pc;
        logic          req;
        logic [15:0]   addr;
        logic          vld;
        logic [15:0]   ir;
        logic [15:0]   opnd;
        logic          od;
        logic          ipc;
        logic          dipc;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [15:0]   pc_init;
    logic [15:0]   lpc_pc;
    int unsigned   ack_delay;
    int unsigned   wait_cnt;
    logic [DW-1:0] mem [0:65535];
    vec_t          tbl [16];

    // PC register model
    always @(posedge clk or posedge rst) begin
        if (rst)           bus.pc <= pc_init;
        else if (bus.lpc)  bus.pc <= lpc_pc;
        else if (bus.ipc)  bus.pc <= bus.pc + 16'd1;
        else if (bus.dipc) bus.pc <= bus.pc + 16'd2;
    end

    // Memory model with a programmable number of wait states
    always @(posedge clk or posedge rst) begin
        if (rst)                             wait_cnt <= 0;
        else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else                                 wait_cnt <= 0;
    end

    always_comb begin
        bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
        bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr] : '0;
    end

    function automatic vec_t mk(logic rdy, logic bbi, logic lpci, logic [15:0] lp,
                                logic req, logic [15:0] addr, logic vld, logic [15:0] ir,
                                logic [15:0] opnd, logic od, logic ipc, logic dipc);
        vec_t v;
        v.rdy = rdy; v.bb = bbi; v.lpc = lpci; v.lpc_pc = lp;
        v.req = req; v.addr = addr; v.vld = vld; v.ir = ir;
        v.opnd = opnd; v.od = od; v.ipc = ipc; v.dipc = dipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drive inputs, check outputs, advance to the next falling edge
    task automatic step(input vec_t v, input string name);
        bus.out_ready = v.rdy;
        bus.bb        = v.bb;
        bus.lpc       = v.lpc;
        lpc_pc        = v.lpc_pc;
        #1;
        chk({name, ".mem_req"},   32'(bus.mem_req),   32'(v.req));
        if (v.req) chk({name, ".mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(v.vld));
        chk({name, ".ir"},        32'(bus.ir),        32'(v.ir));
        chk({name, ".opnd"},      32'(bus.opnd),      32'(v.opnd));
        chk({name, ".is_od"},     32'(bus.is_od),     32'(v.od));
        chk({name, ".ipc"},       32'(bus.ipc),       32'(v.ipc));
        chk({name, ".dipc"},      32'(bus.dipc),      32'(v.dipc));
        chk({name, ".excl"}, {30'd0, bus.ipc & bus.dipc, (bus.ipc | bus.dipc) & (bus.lpc | bus.bb)}, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".mem_req"},   32'(bus.mem_req),   32'd0);
        chk({name, ".mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, ".ir"},        32'(bus.ir),        32'd0);
        chk({name, ".opnd"},      32'(bus.opnd),      32'd0);
        chk({name, ".is_od"},     32'(bus.is_od),     32'd0);
        chk({name, ".ipcs"},      {30'd0, bus.ipc, bus.dipc}, 32'd0);
    endtask

    // Called just after a falling edge; returns one falling edge after release
    task automatic do_reset(input logic [15:0] p, input string name);
        pc_init       = p;
        bus.lpc       = 1'b0;
        bus.bb        = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        #1;
        chk_reset(name);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        pc_init       = 16'h0010;
        lpc_pc        = 16'h0000;
        ack_delay     = 0;
        bus.lpc       = 1'b0;
        bus.bb        = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 16'h1234;
        mem[16'h0020] = 16'h8001;
        mem[16'h0021] = 16'hBEEF;
        mem[16'h0022] = 16'h0042;
        mem[16'h0023] = 16'h0077;
        mem[16'h0030] = 16'h8002;
        mem[16'h0031] = 16'hDEAD;
        mem[16'h0040] = 16'h0100;
        mem[16'h0050] = 16'h0055;
        mem[16'hFFFF] = 16'h8003;
        mem[16'h0000] = 16'h1111;

        //          rdy  bb   lpc  lpc_pc    req  addr      vld  ir        opnd      od   ipc  dipc
        tbl[0]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0010,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        tbl[2]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,1'b0,1'b1,1'b0);
        tbl[3]  = mk(1'b1,1'b0,1'b1,16'h0020, 1'b1,16'h0011,1'b0,16'h1234,16'h0000,1'b0,1'b0,1'b0);
        tbl[4]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0020,1'b0,16'h1234,16'h0000,1'b0,1'b0,1'b0);
        tbl[5]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0021,1'b0,16'h8001,16'h0000,1'b1,1'b0,1'b0);
        tbl[6]  = mk(1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h8001,16'hBEEF,1'b1,1'b0,1'b1);
        tbl[7]  = mk(1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0022,1'b0,16'h8001,16'hBEEF,1'b1,1'b0,1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0042,16'h0000,1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b1,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0042,16'h0000,1'b0,1'b0,1'b0);
        tbl[10] = mk(1'b1,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0042,16'h0000,1'b0,1'b0,1'b0);
        tbl[11] = mk(1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0042,16'h0000,1'b0,1'b1,1'b0);
        tbl[12] = mk(1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0023,1'b0,16'h0042,16'h0000,1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b1,1'b0,1'b1,16'h0040, 1'b0,16'h0000,1'b0,16'h0077,16'h0000,1'b0,1'b0,1'b0);
        tbl[14] = mk(1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0040,1'b0,16'h0077,16'h0000,1'b0,1'b0,1'b0);
        tbl[15] = mk(1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0100,16'h0000,1'b0,1'b1,1'b0);

        @(negedge clk);

        // Zero-wait stream: one-word, flush with ack, OD, backpressure, bus busy, flush in issue
        do_reset(16'h0010, "rst0");
        for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Three wait states, then decode stalls for four cycles
        ack_delay = 3;
        do_reset(16'h0050, "rst1");
        step(mk(1'b0,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), "ws.idle");
        for (int i = 0; i < 4; i++)
            step(mk(1'b0,1'b0,1'b0,16'h0,1'b1,16'h0050,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), $sformatf("ws.fetch%0d", i));
        for (int i = 0; i < 4; i++)
            step(mk(1'b0,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b1,16'h0055,16'h0,1'b0,1'b0,1'b0), $sformatf("ws.stall%0d", i));
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b1,16'h0055,16'h0,1'b0,1'b1,1'b0), "ws.issue");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0051,1'b0,16'h0055,16'h0,1'b0,1'b0,1'b0), "ws.next");

        // Branch while the operand read is outstanding: drain 0x31, discard 0xDEAD, refetch at 0x40
        ack_delay = 2;
        do_reset(16'h0030, "rst2");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), "fl.idle");
        for (int i = 0; i < 3; i++)
            step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0030,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), $sformatf("fl.fetch%0d", i));
        step(mk(1'b1,1'b0,1'b1,16'h0040,1'b1,16'h0031,1'b0,16'h8002,16'h0,1'b1,1'b0,1'b0), "fl.opnd_lpc");
        step(mk(1'b1,1'b0,1'b1,16'h0040,1'b1,16'h0031,1'b0,16'h8002,16'h0,1'b1,1'b0,1'b0), "fl.drain0");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0031,1'b0,16'h8002,16'h0,1'b1,1'b0,1'b0), "fl.drain_ack");
        for (int i = 0; i < 3; i++)
            step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0040,1'b0,16'h8002,16'h0,1'b1,1'b0,1'b0), $sformatf("fl.refetch%0d", i));
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b1,16'h0100,16'h0,1'b0,1'b1,1'b0), "fl.issue");

        // OD at the top of memory: operand address wraps to 0
        ack_delay = 0;
        do_reset(16'hFFFF, "rst3");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0), "wr.idle");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'hFFFF,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0), "wr.fetch");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0000,1'b0,16'h8003,16'h0000,1'b1,1'b0,1'b0), "wr.opnd");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b1,16'h8003,16'h1111,1'b1,1'b0,1'b1), "wr.issue");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0001,1'b0,16'h8003,16'h1111,1'b1,1'b0,1'b0), "wr.next");

        // Reset during a memory wait, then during issue
        ack_delay = 5;
        do_reset(16'h0050, "rst4");
        step(mk(1'b1,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), "rw.idle");
        for (int i = 0; i < 2; i++)
            step(mk(1'b1,1'b0,1'b0,16'h0,1'b1,16'h0050,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), $sformatf("rw.fetch%0d", i));
        ack_delay = 0;
        do_reset(16'h0050, "rw.mid_wait");
        step(mk(1'b0,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), "ri.idle");
        step(mk(1'b0,1'b0,1'b0,16'h0,1'b1,16'h0050,1'b0,16'h0000,16'h0,1'b0,1'b0,1'b0), "ri.fetch");
        step(mk(1'b0,1'b0,1'b0,16'h0,1'b0,16'h0000,1'b1,16'h0055,16'h0,1'b0,1'b0,1'b0), "ri.issue");
        bus.out_ready = 1'b0;
        do_reset(16'h0050, "ri.mid_issue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
